// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Round-robin arbiter driving the select/enable of a shared 4:1
//               mux, with each grant bounded to HOLD_MAX consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CW       = $clog2(HOLD_MAX + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       en,
    output logic       preempt,
    output logic       busy
);

    localparam logic [0:0]    c_ST_IDLE = 1'b0;
    localparam logic [0:0]    c_ST_OWN  = 1'b1;
    localparam logic [CW-1:0] c_HOLD    = CW'(HOLD_MAX);
    localparam logic [CW-1:0] c_ONE     = CW'(1);

    generate
        if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
            $error("rr_mux_arbiter: HOLD_MAX must be in 1..255");
        end
    endgenerate

    logic [0:0]    r_state;
    logic [3:0]    r_gnt;
    logic [1:0]    r_sel;
    logic          r_en;
    logic          r_preempt;
    logic [1:0]    r_ptr;
    logic [CW-1:0] r_cnt;

    logic [0:0]    w_state;
    logic [3:0]    w_gnt;
    logic [1:0]    w_sel;
    logic          w_en;
    logic          w_preempt;
    logic [1:0]    w_ptr;
    logic [CW-1:0] w_cnt;

    logic [1:0]    w_base;
    logic [1:0]    w_idx;
    logic [1:0]    w_win;
    logic          w_found;
    logic [3:0]    w_win_oh;

    // While owning, the pointer is about to become the owner on any handover,
    // so the search starts just after the owner and visits it last.
    always_comb begin
        w_base  = (r_state == c_ST_OWN) ? r_sel : r_ptr;
        w_idx   = w_base;
        w_win   = w_base;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = w_base + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
        w_win_oh = 4'b0001 << w_win;
    end

    always_comb begin
        w_state   = r_state;
        w_gnt     = r_gnt;
        w_sel     = r_sel;
        w_en      = r_en;
        w_preempt = 1'b0;
        w_ptr     = r_ptr;
        w_cnt     = r_cnt;

        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state = c_ST_OWN;
                    w_gnt   = w_win_oh;
                    w_sel   = w_win;
                    w_en    = 1'b1;
                    w_cnt   = c_ONE;
                end
            end
            default: begin
                if (req[r_sel] && (r_cnt < c_HOLD)) begin
                    w_cnt = r_cnt + c_ONE;
                end else begin
                    // Release or expiry: the owner drops to lowest priority.
                    w_ptr     = r_sel;
                    w_preempt = req[r_sel];
                    if (w_found) begin
                        w_gnt = w_win_oh;
                        w_sel = w_win;
                        w_cnt = c_ONE;
                    end else begin
                        w_state = c_ST_IDLE;
                        w_gnt   = 4'b0000;
                        w_en    = 1'b0;
                        w_cnt   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_gnt     <= 4'b0000;
            r_sel     <= 2'b00;
            r_en      <= 1'b0;
            r_preempt <= 1'b0;
            r_ptr     <= 2'd3;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_gnt     <= w_gnt;
            r_sel     <= w_sel;
            r_en      <= w_en;
            r_preempt <= w_preempt;
            r_ptr     <= w_ptr;
            r_cnt     <= w_cnt;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign en      = r_en;
    assign preempt = r_preempt;
    assign busy    = r_en;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Directed bench for rr_mux_arbiter (HOLD_MAX=4 and HOLD_MAX=1)
//               with a cycle-level reference model and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] g4, g1;
    logic [1:0] s4, s1;
    logic       e4, e1, p4, p1, b4, b1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.HOLD_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(g4), .sel(s4), .en(e4), .preempt(p4), .busy(b4)
    );

    rr_mux_arbiter #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(g1), .sel(s1), .en(e1), .preempt(p1), .busy(b1)
    );

    // Reference model: index 0 tracks dut4, index 1 tracks dut1.
    int hold[2] = '{4, 1};
    int m_busy[2], m_own[2], m_ptr[2], m_cnt[2], m_pre[2];

    function automatic int pick(int p, logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int w;
            m_pre[i] = 0;
            if (rst) begin
                m_busy[i] = 0; m_own[i] = 0; m_ptr[i] = 3; m_cnt[i] = 0;
            end else if (m_busy[i] == 0) begin
                w = pick(m_ptr[i], req);
                if (w >= 0) begin
                    m_busy[i] = 1; m_own[i] = w; m_cnt[i] = 1;
                end
            end else if (req[m_own[i]] && m_cnt[i] < hold[i]) begin
                m_cnt[i]++;
            end else begin
                m_pre[i] = req[m_own[i]] ? 1 : 0;
                m_ptr[i] = m_own[i];
                w = pick(m_ptr[i], req);
                if (w >= 0) begin
                    m_own[i] = w; m_cnt[i] = 1;
                end else begin
                    m_busy[i] = 0; m_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        chk_en = 1'b1;
    endtask

    function automatic logic [3:0] oh(int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dut4.gnt", {4'b0, g4}, m_busy[0] ? {4'b0, oh(m_own[0])} : 8'h00);
            chk("dut4.sel", {6'b0, s4}, 8'(m_own[0]));
            chk("dut4.en",  {7'b0, e4}, 8'(m_busy[0]));
            chk("dut4.preempt", {7'b0, p4}, 8'(m_pre[0]));
            chk("dut4.busy", {7'b0, b4}, 8'(m_busy[0]));
            chk("dut4.onehot", 8'($countones(g4) <= 1), 8'd1);
            chk("dut4.sel_idx", 8'(!e4 || (g4 == oh(int'(s4)))), 8'd1);
            chk("dut1.gnt", {4'b0, g1}, m_busy[1] ? {4'b0, oh(m_own[1])} : 8'h00);
            chk("dut1.sel", {6'b0, s1}, 8'(m_own[1]));
            chk("dut1.en",  {7'b0, e1}, 8'(m_busy[1]));
            chk("dut1.preempt", {7'b0, p1}, 8'(m_pre[1]));
            chk("dut1.busy", {7'b0, b1}, 8'(m_busy[1]));
            chk("dut1.onehot", 8'($countones(g1) <= 1), 8'd1);
            chk("dut1.sel_idx", 8'(!e1 || (g1 == oh(int'(s1)))), 8'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [3:0] sweep [16] = '{4'h3, 4'h5, 4'h0, 4'hF, 4'h9, 4'h6, 4'hA, 4'hA,
                               4'hC, 4'h1, 4'h7, 4'hE, 4'hE, 4'hE, 4'hE, 4'h0};

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        tick(); tick();
        chk("t1.rst_gnt", {4'b0, g4}, 8'h00);
        chk("t1.rst_en",  {7'b0, e4}, 8'h00);
        chk("t1.rst_sel", {6'b0, s4}, 8'h00);
        chk("t1.rst_pre", {7'b0, p4}, 8'h00);
        rst = 1'b0;
        tick();
        chk("t1.first_gnt", {4'b0, g4}, 8'h01);
        chk("t1.first_sel", {6'b0, s4}, 8'h00);
        chk("t1.first_en",  {7'b0, e4}, 8'h01);

        // Round-robin handover on release, no bubble.
        req = 4'b1110; tick(); chk("t2.gnt1", {4'b0, g4}, 8'h02);
        req = 4'b1100; tick(); chk("t2.gnt2", {4'b0, g4}, 8'h04);
        req = 4'b1000; tick(); chk("t2.gnt3", {4'b0, g4}, 8'h08);
        chk("t2.no_pre", {7'b0, p4}, 8'h00);
        req = 4'b0000; tick();
        chk("t2.idle_gnt", {4'b0, g4}, 8'h00);
        chk("t2.idle_en",  {7'b0, e4}, 8'h00);

        // Expiry alternation between requesters 0 and 2.
        req = 4'b0101;
        for (int t = 1; t <= 9; t++) begin
            tick();
            chk("t3.gnt", {4'b0, g4}, (t >= 5 && t <= 8) ? 8'h04 : 8'h01);
            chk("t3.pre", {7'b0, p4}, (t == 5 || t == 9) ? 8'h01 : 8'h00);
        end
        req = 4'b0000; tick();

        // Sole requester re-wins on every expiry.
        req = 4'b1000;
        for (int t = 1; t <= 13; t++) begin
            tick();
            chk("t4.gnt", {4'b0, g4}, 8'h08);
            chk("t4.en",  {7'b0, e4}, 8'h01);
            chk("t4.pre", {7'b0, p4}, (t > 1 && (t - 1) % 4 == 0) ? 8'h01 : 8'h00);
        end
        req = 4'b0000; tick();

        // Reset in the middle of a grant.
        req = 4'b0100; tick(); tick();
        chk("t5.pre_rst_gnt", {4'b0, g4}, 8'h04);
        rst = 1'b1; tick();
        chk("t5.rst_gnt", {4'b0, g4}, 8'h00);
        chk("t5.rst_en",  {7'b0, e4}, 8'h00);
        chk("t5.rst_pre", {7'b0, p4}, 8'h00);
        rst = 1'b0; tick();
        chk("t5.regrant", {4'b0, g4}, 8'h04);

        // HOLD_MAX=1 rotates every cycle.
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b0110;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("t6.gnt", {4'b0, g1}, (t % 2 == 1) ? 8'h02 : 8'h04);
            chk("t6.pre", {7'b0, p1}, (t == 1) ? 8'h00 : 8'h01);
        end

        // Mixed request patterns, checked by the model only.
        for (int i = 0; i < 16; i++) begin
            req = sweep[i];
            tick();
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
